ffd: RTL and testbench



---
 rtl/ffd.sv | 66 ++++++
 tb/tb_ffd.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ffd.sv
// D flip-flop with clock enable, async active-low reset and active-high set.
// Define FFD_SYNC_SET_EN to sample set on the clock edge instead.
module ffd #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             enable,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

`ifdef FFD_SYNC_SET_EN

    always_comb begin
        q_d = q_q;
        if (set) begin
            q_d = SET_VALUE;
        end else if (enable) begin
            q_d = D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

`else

    // Gating set with reset makes reset release under a held set an edge.
    logic set_act;
    assign set_act = set & reset;

    always_comb begin
        q_d = q_q;
        if (enable) begin
            q_d = D;
        end
    end

    always_ff @(posedge clk or negedge reset or posedge set_act) begin
        if (!reset) begin
            q_q <= '0;
        end else if (set_act) begin
            q_q <= SET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

`endif

    assign Q  = q_q;
    assign Qn = ~q_q;

endmodule

// File: tb/tb_ffd.sv
// Directed self-checking bench for ffd (WIDTH = 4).
// Build with FFD_SYNC_SET_EN to exercise the synchronous set variant.
module tb_ffd;

    localparam int W = 4;
`ifdef FFD_SYNC_SET_EN
    localparam logic [W-1:0] SV = 4'hA;
`else
    localparam logic [W-1:0] SV = 4'hF;
`endif

    logic         clk;
    logic         reset;
    logic         set;
    logic         enable;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic [W-1:0] Qn;
    logic [W-1:0] e;

    int n_checks;
    int n_fail;

    ffd #(
        .WIDTH     (W),
        .SET_VALUE (SV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .set    (set),
        .enable (enable),
        .D      (D),
        .Q      (Q),
        .Qn     (Qn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        reset  = 1'b0;
        set    = 1'b0;
        enable = 1'b0;
        D      = '0;
        #1;
        e = 4'h0;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL reset_immediate: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (Q !== e || Qn !== ~e) begin
                n_fail++;
                $display("FAIL reset_held[%0d]: Q=%h Qn=%h need %h/%h", i, Q, Qn, e, ~e);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (Q !== e || Qn !== ~e) begin
                n_fail++;
                $display("FAIL reset_release[%0d]: Q=%h Qn=%h need %h/%h", i, Q, Qn, e, ~e);
            end
        end
    endtask

`ifndef FFD_SYNC_SET_EN
    task automatic test_async_set;
        @(negedge clk);
        #1;
        set = 1'b1;
        #1;
        e = SV;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL async_set_immediate: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
        repeat (5) @(posedge clk);
        #1;
        set = 1'b0;
        #1;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL async_set_release: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL async_set_hold: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
    endtask
`else
    task automatic test_sync_set;
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        set = 1'b1;
        #2;
        set = 1'b0;
        e = 4'h0;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL sync_set_no_async: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL sync_set_short_pulse: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
        @(negedge clk);
        set    = 1'b1;
        enable = 1'b0;
        #1;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL sync_set_pre_edge: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
        @(posedge clk);
        #1;
        e = 4'hA;
        n_checks++;
        if (Q !== e || Qn !== 4'h5) begin
            n_fail++;
            $display("FAIL sync_set_edge: Q=%h Qn=%h need %h/%h", Q, Qn, e, 4'h5);
        end
        @(negedge clk);
        set    = 1'b1;
        enable = 1'b1;
        D      = 4'h3;
        @(posedge clk);
        #1;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL sync_set_over_enable: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
        @(negedge clk);
        set    = 1'b0;
        enable = 1'b0;
    endtask
`endif

    task automatic test_load;
        logic [W-1:0] prev;
        logic [W-1:0] vec [3];
        vec[0] = 4'h5;
        vec[1] = 4'h3;
        vec[2] = 4'h0;
        for (int i = 0; i < 3; i++) begin
            prev = (i == 0) ? Q : vec[i-1];
            @(negedge clk);
            enable = 1'b1;
            D      = vec[i];
            #1;
            n_checks++;
            if (Q !== prev || Qn !== ~prev) begin
                n_fail++;
                $display("FAIL load_pre_edge[%0d]: Q=%h Qn=%h need %h/%h", i, Q, Qn, prev, ~prev);
            end
            @(posedge clk);
            #1;
            e = vec[i];
            n_checks++;
            if (Q !== e || Qn !== ~e) begin
                n_fail++;
                $display("FAIL load_edge[%0d]: Q=%h Qn=%h need %h/%h", i, Q, Qn, e, ~e);
            end
        end
    endtask

    task automatic test_hold;
        @(negedge clk);
        enable = 1'b1;
        D      = 4'hF;
        @(negedge clk);
        enable = 1'b0;
        D      = 4'h0;
        e = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            D = (i[0]) ? 4'h6 : 4'h0;
            n_checks++;
            if (Q !== e || Qn !== ~e) begin
                n_fail++;
                $display("FAIL hold[%0d]: Q=%h Qn=%h need %h/%h", i, Q, Qn, e, ~e);
            end
        end
        @(negedge clk);
        enable = 1'b1;
        D      = 4'h0;
        @(posedge clk);
        #1;
        e = 4'h0;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL hold_reenable: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
        @(negedge clk);
        enable = 1'b1;
        D      = 4'h9;
        #1;
        D      = 4'h6;
        #2;
        D      = 4'hC;
        enable = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL between_edges: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
    endtask

    task automatic test_priority;
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b0;
        set    = 1'b1;
        #1;
        e = 4'h0;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL prio_reset_over_set: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL prio_reset_held: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
        reset = 1'b1;
        #1;
`ifdef FFD_SYNC_SET_EN
        e = 4'h0;
`else
        e = SV;
`endif
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL prio_reset_release: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
        @(posedge clk);
        #1;
        set = 1'b0;
        #1;
        e = SV;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL prio_set_retained: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
        reset = 1'b0;
        #1;
        e = 4'h0;
        n_checks++;
        if (Q !== e || Qn !== ~e) begin
            n_fail++;
            $display("FAIL prio_async_clear: Q=%h Qn=%h need %h/%h", Q, Qn, e, ~e);
        end
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
`ifndef FFD_SYNC_SET_EN
        test_async_set();
`else
        test_sync_set();
`endif
        test_load();
        test_hold();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
